// File: rtl/ppu_pkg.sv
// ppu_pkg: shared sizing helpers for the PPU datapath.
//   te_bits / frac_full_size : FIR field widths for a given posit (N, ES).
//   float_exp_bits / float_mant_bits / float_qnan : IEEE-754 format constants
//   for FSIZE = 16, 32 or 64.
// The FIR record itself (fir_t) depends on N/ES, so each user declares it
// locally from these widths.
package ppu_pkg;

  // Signed scale field: wide enough for +-(N-1)*2^ES with headroom.
  function automatic int te_bits(input int n, input int es);
    return es + $clog2(n) + 2;
  endfunction

  // Significand including the hidden bit at the MSB.
  function automatic int frac_full_size(input int n, input int es);
    return n - es - 1;
  endfunction

  function automatic int float_exp_bits(input int fsize);
    case (fsize)
      16:      return 5;
      64:      return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int float_mant_bits(input int fsize);
    case (fsize)
      16:      return 10;
      64:      return 52;
      default: return 23;
    endcase
  endfunction

  function automatic logic [63:0] float_qnan(input int fsize);
    case (fsize)
      16:      return 64'h0000_0000_0000_7E00;
      64:      return 64'h7FF8_0000_0000_0000;
      default: return 64'h0000_0000_7FC0_0000;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/round_rne.sv
// round_rne: round-to-nearest-even increment on a W-bit mantissa.
//   mant_i/guard_i/sticky_i : truncated mantissa and the bits below it
//   mant_o/carry_o          : rounded mantissa and carry out of its MSB
// Purely combinational; the caller decides what a carry means (exponent bump,
// subnormal promotion, overflow).
module round_rne #(
  parameter int W = 23
) (
  input  logic [W-1:0] mant_i,
  input  logic         guard_i,
  input  logic         sticky_i,
  output logic [W-1:0] mant_o,
  output logic         carry_o
);
  logic inc;

  // Ties (guard set, nothing below) go up only when the lsb is odd.
  assign inc = guard_i & (sticky_i | mant_i[0]);
  assign {carry_o, mant_o} = {1'b0, mant_i} + {{W{1'b0}}, inc};
endmodule

// File: rtl/ppu_fir_to_float.sv
// ppu_fir_to_float: 2-stage FIR -> IEEE-754 (FSIZE bits) converter, RNE.
//   clk_i, rst_i (async, active-low)
//   in_valid_i / in_ready_o : input handshake
//   fir_i = {sign, te (signed), frac (hidden 1 at MSB)}, is_zero_i, is_nar_i, tag_i
//   out_valid_o / out_ready_i : output handshake
//   float_o, tag_o : registered result and its tag
// S1 registers special flags, biased exponent and the subnormal shift amount;
// S2 shifts, rounds and packs. Outputs come straight from S2 registers.
module ppu_fir_to_float
  import ppu_pkg::*;
#(
  parameter  int N              = 16,
  parameter  int ES             = 1,
  parameter  int FSIZE          = 32,
  parameter  int TAG_W          = 4,
  localparam int TE_BITS        = te_bits(N, ES),
  localparam int FRAC_FULL_SIZE = frac_full_size(N, ES),
  localparam int FIR_W          = 1 + TE_BITS + FRAC_FULL_SIZE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [FIR_W-1:0] fir_i,
  input  logic             is_zero_i,
  input  logic             is_nar_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [FSIZE-1:0] float_o,
  output logic [TAG_W-1:0] tag_o
);
  localparam int EB     = float_exp_bits(FSIZE);
  localparam int MB     = float_mant_bits(FSIZE);
  localparam int BIAS   = (1 << (EB - 1)) - 1;
  // Biased exponent must hold both the posit scale range and the float bias.
  localparam int BE_W   = max_int(TE_BITS, EB) + 2;
  localparam int SH_MAX = MB + 2;
  localparam int SH_W   = $clog2(SH_MAX + 1);
  // Room below the significand so a saturated shift loses nothing to sticky.
  localparam int XW     = max_int(FRAC_FULL_SIZE, MB + 1) + SH_MAX;
  localparam int EF_W   = EB + 1;

  localparam logic [FSIZE-1:0]       QNAN   = FSIZE'(float_qnan(FSIZE));
  localparam logic signed [BE_W-1:0] BE_INF = BE_W'((1 << EB) - 1);
  localparam logic signed [BE_W-1:0] SH_SAT = BE_W'(SH_MAX);
  localparam logic [EF_W-1:0]        EF_INF = EF_W'((1 << EB) - 1);

  typedef struct packed {
    logic                      sign;
    logic [TE_BITS-1:0]        te;
    logic [FRAC_FULL_SIZE-1:0] frac;
  } fir_t;

  typedef struct packed {
    logic                      nar;
    logic                      zero;
    logic                      ovf;
    logic                      sign;
    logic [EB-1:0]             be;
    logic [SH_W-1:0]           shamt;
    logic [FRAC_FULL_SIZE-1:0] frac;
    logic [TAG_W-1:0]          tag;
  } s1_t;

  fir_t fir;
  s1_t  s1_d, s1_q;
  logic v1, v2, ready1, ready2;

  logic signed [BE_W-1:0] be_c, sub_amt;
  logic                   is_sub;

  assign fir = fir_i;

  // Ready chain: each stage accepts when empty or when the stage ahead moves.
  assign ready2     = !v2 | out_ready_i;
  assign ready1     = !v1 | ready2;
  assign in_ready_o = ready1;

  // ---------------- S1: decode ----------------
  always_comb begin
    be_c     = BE_W'(signed'(fir.te)) + BE_W'(BIAS);
    sub_amt  = BE_W'(1) - be_c;
    is_sub   = be_c[BE_W-1] | (be_c == '0);
    s1_d     = '0;
    s1_d.nar  = is_nar_i;
    s1_d.zero = is_zero_i;
    s1_d.ovf  = (be_c >= BE_INF);
    s1_d.sign = fir.sign;
    s1_d.be   = be_c[EB-1:0];
    s1_d.frac = fir.frac;
    s1_d.tag  = tag_i;
    if (is_sub)
      s1_d.shamt = (sub_amt > SH_SAT) ? SH_W'(SH_MAX) : sub_amt[SH_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v1   <= 1'b0;
      s1_q <= '0;
    end else if (ready1) begin
      v1 <= in_valid_i;
      if (in_valid_i) s1_q <= s1_d;
    end
  end

  // ---------------- S2: shift, round, pack ----------------
  logic [XW-1:0]    x_sh;
  logic [MB-1:0]    mant_rnd;
  logic             carry;
  logic [EF_W-1:0]  ef;
  logic [FSIZE-1:0] float_d;

  assign x_sh = {s1_q.frac, {(XW - FRAC_FULL_SIZE){1'b0}}} >> s1_q.shamt;

  round_rne #(.W(MB)) u_round (
    .mant_i  (x_sh[XW-2 -: MB]),
    .guard_i (x_sh[XW-MB-2]),
    .sticky_i(|x_sh[XW-MB-3:0]),
    .mant_o  (mant_rnd),
    .carry_o (carry)
  );

  always_comb begin
    // Hidden bit still in place means the normal path (shift of 0); a
    // subnormal has it shifted out, so its exponent field starts at 0 and a
    // rounding carry lands it on the minimum normal.
    ef      = {1'b0, (x_sh[XW-1] ? s1_q.be : {EB{1'b0}})} + EF_W'(carry);
    float_d = '0;
    if (s1_q.nar)
      float_d = QNAN;
    else if (s1_q.zero)
      float_d = '0;
    else if (s1_q.ovf || (ef >= EF_INF))
      float_d = {s1_q.sign, {EB{1'b1}}, {MB{1'b0}}};
    else
      float_d = {s1_q.sign, ef[EB-1:0], mant_rnd};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v2      <= 1'b0;
      float_o <= '0;
      tag_o   <= '0;
    end else if (ready2) begin
      v2 <= v1;
      if (v1) begin
        float_o <= float_d;
        tag_o   <= s1_q.tag;
      end
    end
  end

  assign out_valid_o = v2;
endmodule

// File: tb/tb_ppu_fir_to_float.sv
module tb_ppu_fir_to_float;
  import ppu_pkg::*;

  localparam int A_TE = te_bits(16, 1);
  localparam int A_FF = frac_full_size(16, 1);
  localparam int B_TE = te_bits(32, 2);
  localparam int B_FF = frac_full_size(32, 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=16 ES=1 FSIZE=32
  logic               a_in_valid = 1'b0, a_zero = 1'b0, a_nar = 1'b0, a_out_ready = 1'b1;
  logic               a_in_ready, a_out_valid;
  logic [A_TE+A_FF:0] a_fir = '0;
  logic [3:0]         a_tag_i = '0, a_tag_o;
  logic [31:0]        a_float;
  // Instance B: N=32 ES=2 FSIZE=16
  logic               b_in_valid = 1'b0, b_zero = 1'b0, b_nar = 1'b0, b_out_ready = 1'b1;
  logic               b_in_ready, b_out_valid;
  logic [B_TE+B_FF:0] b_fir = '0;
  logic [3:0]         b_tag_i = '0, b_tag_o;
  logic [15:0]        b_float;

  ppu_fir_to_float #(.N(16), .ES(1), .FSIZE(32), .TAG_W(4)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .fir_i(a_fir), .is_zero_i(a_zero), .is_nar_i(a_nar), .tag_i(a_tag_i),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .float_o(a_float), .tag_o(a_tag_o));

  ppu_fir_to_float #(.N(32), .ES(2), .FSIZE(16), .TAG_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .fir_i(b_fir), .is_zero_i(b_zero), .is_nar_i(b_nar), .tag_i(b_tag_i),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .float_o(b_float), .tag_o(b_tag_o));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          sgn;
    int          te;
    logic [63:0] frac;
    bit          zero;
    bit          nar;
    logic [3:0]  tag;
    logic [63:0] want;
    bit          has_want;
  } beat_t;

  function automatic beat_t mk(input bit sgn, input int te, input logic [63:0] frac,
                               input bit zero, input bit nar, input logic [3:0] tag,
                               input logic [63:0] want, input bit has_want);
    beat_t b;
    b.sgn = sgn; b.te = te; b.frac = frac; b.zero = zero; b.nar = nar;
    b.tag = tag; b.want = want; b.has_want = has_want;
    return b;
  endfunction

  // Value-level reference: value = frac * 2^(te-(ffs-1)); quantise to the
  // float's lsb weight 2^qe with RNE, then classify the integer mantissa.
  function automatic logic [63:0] ref_float(input int fs, input int ffs, input beat_t b);
    int eb, mb, bias, qe, n, ef;
    logic [63:0] m, rem, half, s;
    eb   = (fs == 16) ? 5 : (fs == 64) ? 11 : 8;
    mb   = (fs == 16) ? 10 : (fs == 64) ? 52 : 23;
    bias = (1 << (eb - 1)) - 1;
    if (b.nar) return (fs == 16) ? 64'h7E00 : (fs == 64) ? 64'h7FF8000000000000 : 64'h7FC00000;
    if (b.zero) return 64'd0;
    s  = 64'(b.sgn) << (fs - 1);
    qe = ((te_max(b.te, 1 - bias)) - mb);
    n  = qe - b.te + (ffs - 1);
    if (n <= 0) m = b.frac << (-n);
    else if (n > 40) m = 64'd0;
    else begin
      rem  = b.frac & ((64'd1 << n) - 64'd1);
      half = 64'd1 << (n - 1);
      m    = b.frac >> n;
      if (rem > half || (rem == half && m[0])) m = m + 64'd1;
    end
    if (m >= (64'd1 << (mb + 1))) begin m = m >> 1; qe = qe + 1; end
    if (m < (64'd1 << mb)) return s | m;
    ef = qe + mb + bias;
    if (ef >= (1 << eb) - 1) return s | (64'((1 << eb) - 1) << mb);
    return s | (64'(ef) << mb) | (m - (64'd1 << mb));
  endfunction

  function automatic int te_max(input int a, input int c);
    return (a > c) ? a : c;
  endfunction

  function automatic beat_t rnd_beat(input bit inst, input logic [3:0] tag);
    beat_t b;
    int r;
    r = $urandom_range(0, 19);
    b = mk($urandom_range(0, 1), 0, 64'd0, (r == 0) || (r == 1), (r == 1) || (r == 2), tag, 64'd0, 0);
    if (inst) begin
      b.te   = (r < 6) ? int'($urandom_range(0, 511)) - 256 : int'($urandom_range(0, 60)) - 40;
      b.frac = {35'd0, 1'b1, 28'($urandom)};
      if (r == 3) b.frac = {35'd0, 1'b1, 10'($urandom), 1'b1, 17'd0};  // exact tie
    end else begin
      b.te   = int'($urandom_range(0, 127)) - 64;
      b.frac = {50'd0, 1'b1, 13'($urandom)};
    end
    return b;
  endfunction

  // Drive one cycle on instance inst (0=A, 1=B) and sample before the edge.
  task automatic step(input bit inst, input bit vld, input beat_t b, input bit ordy,
                      output bit acc, output bit ov, output bit ir,
                      output logic [63:0] f, output logic [3:0] t);
    @(negedge clk);
    a_in_valid = vld & !inst;
    b_in_valid = vld & inst;
    a_fir   = {b.sgn, A_TE'(b.te), b.frac[A_FF-1:0]};
    b_fir   = {b.sgn, B_TE'(b.te), b.frac[B_FF-1:0]};
    a_zero  = b.zero; b_zero = b.zero;
    a_nar   = b.nar;  b_nar  = b.nar;
    a_tag_i = b.tag;  b_tag_i = b.tag;
    a_out_ready = inst ? 1'b1 : ordy;
    b_out_ready = inst ? ordy : 1'b1;
    #1;
    if (inst) begin ir = b_in_ready; ov = b_out_valid; f = 64'(b_float); t = b_tag_o; end
    else      begin ir = a_in_ready; ov = a_out_valid; f = 64'(a_float); t = a_tag_o; end
    acc = vld & ir;
    @(posedge clk);
  endtask

  // rmode: 0 always ready, 1 random ready, 2 pattern 1,0,0,1,1,0
  task automatic run_stream(input bit inst, input beat_t beats[$], input int rmode,
                            input bit chk_lat, input string nm);
    logic [63:0] exp_f[$];
    logic [3:0]  exp_t[$];
    int          acc_cyc[$];
    int          cyc;
    bit          acc, ov, ir, ordy, vld;
    logic [63:0] f;
    logic [3:0]  t;
    beat_t       b;
    int          fs, ff;
    cyc = 0;
    fs  = inst ? 16 : 32;
    ff  = inst ? B_FF : A_FF;
    while ((beats.size() > 0 || exp_f.size() > 0) && cyc < 3000) begin
      vld = beats.size() > 0;
      if (vld) b = beats[0];
      else     b = mk(0, 0, 64'd0, 0, 0, 4'd0, 64'd0, 0);
      case (rmode)
        0:       ordy = 1'b1;
        1:       ordy = ($urandom_range(0, 9) < 7);
        default: ordy = (cyc % 6 == 0) || (cyc % 6 == 3) || (cyc % 6 == 4);
      endcase
      step(inst, vld, b, ordy, acc, ov, ir, f, t);
      n_cmp++;
      if (ir !== !(exp_f.size() == 2 && !ordy)) begin
        n_bad++;
        $display("FAIL %s in_ready cyc %0d: got %b want %b", nm, cyc, ir, !(exp_f.size() == 2 && !ordy));
      end
      if (ov) begin
        n_cmp++;
        if (exp_f.size() == 0) begin
          n_bad++;
          $display("FAIL %s spurious out_valid cyc %0d: got float %h tag %0d", nm, cyc, f, t);
        end else begin
          if (f !== exp_f[0] || t !== exp_t[0]) begin
            n_bad++;
            $display("FAIL %s data cyc %0d: got %h/tag %0d want %h/tag %0d", nm, cyc, f, t, exp_f[0], exp_t[0]);
          end
          if (ordy) begin
            if (chk_lat) begin
              n_cmp++;
              if (cyc - acc_cyc[0] != 2) begin
                n_bad++;
                $display("FAIL %s latency tag %0d: got %0d want 2", nm, t, cyc - acc_cyc[0]);
              end
            end
            void'(exp_f.pop_front()); void'(exp_t.pop_front()); void'(acc_cyc.pop_front());
          end
        end
      end
      if (acc) begin
        exp_f.push_back(b.has_want ? b.want : ref_float(fs, ff, b));
        exp_t.push_back(b.tag);
        acc_cyc.push_back(cyc);
        void'(beats.pop_front());
      end
      cyc++;
    end
    n_cmp++;
    if (beats.size() > 0 || exp_f.size() > 0) begin
      n_bad++;
      $display("FAIL %s timeout: got %0d unsent %0d undelivered, want 0", nm, beats.size(), exp_f.size());
    end
  endtask

  task automatic test_reset;
    #3;
    n_cmp += 8;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b %b want 0", a_out_valid, b_out_valid); end
    if (a_float !== 32'd0)   begin n_bad++; $display("FAIL reset a_float: got %h want 0", a_float); end
    if (b_float !== 16'd0)   begin n_bad++; $display("FAIL reset b_float: got %h want 0", b_float); end
    if (a_tag_o !== 4'd0)    begin n_bad++; $display("FAIL reset a_tag: got %h want 0", a_tag_o); end
    if (b_tag_o !== 4'd0)    begin n_bad++; $display("FAIL reset b_tag: got %h want 0", b_tag_o); end
    if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset a_in_ready: got %b want 1", a_in_ready); end
    if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset b_in_ready: got %b want 1", b_in_ready); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset a: got rdy %b vld %b want 1 0", a_in_ready, a_out_valid); end
  endtask

  task automatic test_directed_a;
    beat_t q[$];
    q.push_back(mk(0,  0, 64'h2000, 0, 0, 4'd1, 64'h3F800000, 1));
    q.push_back(mk(0, -1, 64'h2000, 0, 0, 4'd2, 64'h3F000000, 1));
    q.push_back(mk(1,  0, 64'h2000, 0, 0, 4'd3, 64'hBF800000, 1));
    q.push_back(mk(0,  0, 64'h3000, 0, 0, 4'd4, 64'h3FC00000, 1));
    q.push_back(mk(0,  5, 64'h2000, 0, 1, 4'd5, 64'h7FC00000, 1));
    q.push_back(mk(1,  5, 64'h2000, 1, 0, 4'd6, 64'h00000000, 1));
    q.push_back(mk(0,  5, 64'h2000, 1, 1, 4'd7, 64'h7FC00000, 1));
    run_stream(0, q, 0, 1, "directed_a");
  endtask

  task automatic test_range_b;
    beat_t q[$];
    q.push_back(mk(0,  16, 64'h10000000, 0, 0, 4'd0,  64'h7C00, 1));
    q.push_back(mk(0,  15, 64'h1FFFFFFF, 0, 0, 4'd1,  64'h7C00, 1));
    q.push_back(mk(1,  15, 64'h10000000, 0, 0, 4'd2,  64'hF800, 1));
    q.push_back(mk(0, -14, 64'h10000000, 0, 0, 4'd3,  64'h0400, 1));
    q.push_back(mk(0, -15, 64'h10000000, 0, 0, 4'd4,  64'h0200, 1));
    q.push_back(mk(0, -15, 64'h1FFFFFFF, 0, 0, 4'd5,  64'h0400, 1));
    q.push_back(mk(0, -24, 64'h10000000, 0, 0, 4'd6,  64'h0001, 1));
    q.push_back(mk(0, -25, 64'h10000000, 0, 0, 4'd7,  64'h0000, 1));
    q.push_back(mk(0, -25, 64'h10000001, 0, 0, 4'd8,  64'h0001, 1));
    q.push_back(mk(0, -30, 64'h10000000, 0, 0, 4'd9,  64'h0000, 1));
    q.push_back(mk(0,   0, 64'h10020000, 0, 0, 4'd10, 64'h3C00, 1));
    q.push_back(mk(0,   0, 64'h10060000, 0, 0, 4'd11, 64'h3C02, 1));
    q.push_back(mk(0,   0, 64'h10020001, 0, 0, 4'd12, 64'h3C01, 1));
    q.push_back(mk(0,   0, 64'h10000000, 1, 1, 4'd13, 64'h7E00, 1));
    run_stream(1, q, 0, 1, "range_b");
  endtask

  task automatic test_random;
    beat_t q[$];
    for (int i = 0; i < 200; i++) q.push_back(rnd_beat(0, 4'(i)));
    run_stream(0, q, 1, 0, "random_a");
    q.delete();
    for (int i = 0; i < 300; i++) q.push_back(rnd_beat(1, 4'(i)));
    run_stream(1, q, 1, 0, "random_b");
    q.delete();
    for (int i = 0; i < 60; i++) q.push_back(rnd_beat(1, 4'(i)));
    run_stream(1, q, 0, 1, "stream_b");
  endtask

  task automatic test_back_to_back;
    beat_t q[$];
    for (int i = 0; i < 6; i++) q.push_back(rnd_beat(0, 4'(i)));
    run_stream(0, q, 2, 0, "back_to_back");
  endtask

  task automatic test_reset_mid;
    beat_t q[$];
    bit acc, ov, ir;
    logic [63:0] f;
    logic [3:0] t;
    step(0, 1, mk(0, 0, 64'h2000, 0, 0, 4'd9,  64'd0, 0), 0, acc, ov, ir, f, t);
    step(0, 1, mk(0, 1, 64'h2000, 0, 0, 4'd10, 64'd0, 0), 0, acc, ov, ir, f, t);
    a_in_valid = 1'b0;
    #1;
    n_cmp++;
    if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst in_flight: got out_valid %b want 1", a_out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst out_valid: got %b want 0", a_out_valid); end
    if (a_float !== 32'd0 || a_tag_o !== 4'd0) begin n_bad++; $display("FAIL midrst data: got %h/%0d want 0/0", a_float, a_tag_o); end
    if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst in_ready: got %b want 1", a_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(mk(0, 0, 64'h2000, 0, 0, 4'd12, 64'h3F800000, 1));
    run_stream(0, q, 0, 1, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed_a();
    test_range_b();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end
endmodule
